// File: rtl/riscv_mem_pkg.sv
// Shared definitions for the RISC-V memory responder.
// Holds the IO address map, the CONS_STAT bit layout and the region decode used by
// riscv_mem_responder. No ports; imported by the responder.
package riscv_mem_pkg;

    // IO window base; the four registers sit at word offsets inside a 16-byte block.
    localparam logic [31:0] IO_BASE       = 32'h8000_0000;
    localparam logic [3:0]  CONS_TX_OFS   = 4'h0;
    localparam logic [3:0]  CONS_STAT_OFS = 4'h4;
    localparam logic [3:0]  TIME_LO_OFS   = 4'h8;
    localparam logic [3:0]  TIME_HI_OFS   = 4'hC;

    // CONS_STAT layout
    localparam int unsigned STAT_FULL_BIT  = 0;
    localparam int unsigned STAT_EMPTY_BIT = 1;
    localparam int unsigned STAT_OVF_BIT   = 2;
    localparam int unsigned STAT_COUNT_LSB = 8;
    localparam int unsigned STAT_COUNT_W   = 8;

    typedef enum logic [1:0] {
        REG_RAM,
        REG_IO,
        REG_NONE
    } region_e;

    // RAM occupies the first ram_words words; anything above it (below IO) is unmapped,
    // so high address bits never alias back onto RAM.
    function automatic region_e decode_region(input logic [31:0] addr,
                                              input int unsigned ram_words);
        if (addr[31:4] == IO_BASE[31:4]) begin
            return REG_IO;
        end else if ((addr >> 2) < ram_words) begin
            return REG_RAM;
        end else begin
            return REG_NONE;
        end
    endfunction

endpackage

// File: rtl/byte_fifo.sv
// Synchronous byte FIFO used as the console TX buffer.
// Ports:
//   clk, reset      clock and synchronous active-high reset
//   push, push_data enqueue request and byte (ignored when full unless popping too)
//   pop             dequeue request (ignored when empty)
//   pop_data        head byte (undefined content when empty)
//   full, empty     status flags
//   count           current occupancy, 0..DEPTH
module byte_fifo #(
    parameter int unsigned DEPTH = 16,
    localparam int unsigned AW   = $clog2(DEPTH),
    localparam int unsigned CW   = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push,
    input  logic [7:0]    push_data,
    input  logic          pop,
    output logic [7:0]    pop_data,
    output logic          full,
    output logic          empty,
    output logic [CW-1:0] count
);

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [CW-1:0] count_q;
    logic          do_push;
    logic          do_pop;

    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);
    assign count = count_q;

    assign do_pop  = pop && !empty;
    // A push on a full FIFO is still taken when the head leaves in the same cycle.
    assign do_push = push && (!full || do_pop);

    assign pop_data = mem[rd_ptr_q];

    // Storage is not reset; only the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (do_push && !reset) begin
            mem[wr_ptr_q] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/riscv_mem_responder.sv
// Memory-side responder for the multi-cycle RISC-V core's unified bus.
// Serves fetches, loads and byte-masked stores from a word RAM with one-cycle registered
// read latency (read-first on same-word collisions), plus an MMIO block at 0x8000_0000:
//   +0x0 CONS_TX   (write pushes a byte, reads 0)
//   +0x4 CONS_STAT (full, empty, sticky overflow, occupancy; any write clears overflow)
//   +0x8 TIME_LO   (low timer word; read snapshots the high word into a shadow)
//   +0xC TIME_HI   (shadowed high word)
// Ports:
//   clk, reset            clock and synchronous active-high reset
//   Address               byte address from core, bits 1:0 ignored
//   WriteData, MemWrite   store data (lane-shifted) and strobe
//   WriteMask             byte-lane enables
//   ReadData              registered read data for the address of the previous cycle
//   cons_valid, cons_data console FIFO head (ready/valid)
//   cons_ready            console sink accepts the head byte
module riscv_mem_responder
    import riscv_mem_pkg::*;
#(
    parameter int unsigned RAM_WORDS  = 4096,
    parameter int unsigned FIFO_DEPTH = 16,
    parameter string       INIT_FILE  = "mem.hex"
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] Address,
    input  logic [31:0] WriteData,
    input  logic        MemWrite,
    input  logic [3:0]  WriteMask,
    output logic [31:0] ReadData,
    output logic        cons_valid,
    output logic [7:0]  cons_data,
    input  logic        cons_ready
);

    localparam int unsigned RAM_AW = $clog2(RAM_WORDS);
    localparam int unsigned CNT_W  = $clog2(FIFO_DEPTH + 1);

    // ------------------------------------------------------------------------
    // Address decode
    // ------------------------------------------------------------------------
    region_e           region;
    logic [3:0]        io_ofs;
    logic [RAM_AW-1:0] ram_idx;
    logic              ram_we;
    logic              io_wr;

    assign region  = decode_region(Address, RAM_WORDS);
    assign io_ofs  = {Address[3:2], 2'b00};
    assign ram_idx = Address[RAM_AW+1:2];

    // Stores are dropped in a reset cycle.
    assign ram_we = (region == REG_RAM) && MemWrite && !reset;
    assign io_wr  = (region == REG_IO) && MemWrite && !reset;

    // ------------------------------------------------------------------------
    // RAM
    // ------------------------------------------------------------------------
    // The core fetches 0x0 until a bench writes a program in.
    logic [31:0] mem [RAM_WORDS];
    localparam string unused_init_file = INIT_FILE;

    logic [31:0] ram_rdata;

    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (ram_we && WriteMask[i]) begin
                mem[ram_idx][8*i +: 8] <= WriteData[8*i +: 8];
            end
        end
    end

    // Sampled at the same edge as the write, so a colliding read sees the old word.
    assign ram_rdata = mem[ram_idx];

    // ------------------------------------------------------------------------
    // Console FIFO
    // ------------------------------------------------------------------------
    logic             push_req;
    logic             pop;
    logic             stat_clr;
    logic [7:0]       fifo_head;
    logic             fifo_full;
    logic             fifo_empty;
    logic [CNT_W-1:0] fifo_count;
    logic             overflow_q;

    assign push_req = io_wr && (io_ofs == CONS_TX_OFS) && WriteMask[0];
    assign stat_clr = io_wr && (io_ofs == CONS_STAT_OFS) && (|WriteMask);
    assign pop      = cons_valid && cons_ready;

    byte_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_cons_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push_req),
        .push_data (WriteData[7:0]),
        .pop       (pop),
        .pop_data  (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    assign cons_valid = !fifo_empty;
    assign cons_data  = fifo_empty ? 8'h00 : fifo_head;

    // A dropped push wins over a same-cycle clear so the loss is never hidden.
    always_ff @(posedge clk) begin
        if (reset) begin
            overflow_q <= 1'b0;
        end else if (push_req && fifo_full && !pop) begin
            overflow_q <= 1'b1;
        end else if (stat_clr) begin
            overflow_q <= 1'b0;
        end
    end

    // ------------------------------------------------------------------------
    // Timer with shadowed high word
    // ------------------------------------------------------------------------
    logic [63:0] timer_q;
    logic [31:0] shadow_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            timer_q  <= '0;
            shadow_q <= '0;
        end else begin
            timer_q <= timer_q + 64'd1;
            if ((region == REG_IO) && (io_ofs == TIME_LO_OFS)) begin
                shadow_q <= timer_q[63:32];
            end
        end
    end

    // ------------------------------------------------------------------------
    // Read mux
    // ------------------------------------------------------------------------
    logic [31:0] stat_word;
    logic [31:0] io_rdata;

    always_comb begin
        stat_word                                   = '0;
        stat_word[STAT_FULL_BIT]                    = fifo_full;
        stat_word[STAT_EMPTY_BIT]                   = fifo_empty;
        stat_word[STAT_OVF_BIT]                     = overflow_q;
        stat_word[STAT_COUNT_LSB +: STAT_COUNT_W]   = STAT_COUNT_W'(fifo_count);
    end

    always_comb begin
        io_rdata = '0;
        case (io_ofs)
            CONS_STAT_OFS: io_rdata = stat_word;
            TIME_LO_OFS:   io_rdata = timer_q[31:0];
            TIME_HI_OFS:   io_rdata = shadow_q;
            default:       io_rdata = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ReadData <= '0;
        end else begin
            case (region)
                REG_RAM: ReadData <= ram_rdata;
                REG_IO:  ReadData <= io_rdata;
                default: ReadData <= '0;
            endcase
        end
    end

endmodule

// File: tb/tb_riscv_mem_responder.sv
module tb_riscv_mem_responder;

    localparam logic [31:0] IO      = 32'h8000_0000;
    localparam logic [31:0] A_TX    = IO + 32'h0;
    localparam logic [31:0] A_STAT  = IO + 32'h4;
    localparam logic [31:0] A_LO    = IO + 32'h8;
    localparam logic [31:0] A_HI    = IO + 32'hC;

    logic        clk;
    logic        reset;
    logic [31:0] Address;
    logic [31:0] WriteData;
    logic        MemWrite;
    logic [3:0]  WriteMask;
    logic [31:0] ReadData;
    logic        cons_valid;
    logic [7:0]  cons_data;
    logic        cons_ready;

    int total;
    int bad;

    logic [31:0] exp_q[$];
    logic [7:0]  byte_q[$];

    riscv_mem_responder dut (
        .clk        (clk),
        .reset      (reset),
        .Address    (Address),
        .WriteData  (WriteData),
        .MemWrite   (MemWrite),
        .WriteMask  (WriteMask),
        .ReadData   (ReadData),
        .cons_valid (cons_valid),
        .cons_data  (cons_data),
        .cons_ready (cons_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] m);
        Address   = a;
        WriteData = d;
        WriteMask = m;
        MemWrite  = 1'b1;
        cyc();
        MemWrite  = 1'b0;
        WriteMask = 4'b0000;
    endtask

    task automatic rd(input logic [31:0] a, input logic [31:0] e, input string tag);
        Address  = a;
        MemWrite = 1'b0;
        exp_q.push_back(e);
        cyc();
        check(tag, ReadData, exp_q.pop_front());
    endtask

    task automatic drain(input string tag);
        cons_ready = 1'b1;
        while (byte_q.size() > 0) begin
            check({tag, "_valid"}, {31'b0, cons_valid}, 32'd1);
            check({tag, "_data"}, {24'b0, cons_data}, {24'b0, byte_q.pop_front()});
            cyc();
        end
        check({tag, "_empty"}, {31'b0, cons_valid}, 32'd0);
        cons_ready = 1'b0;
    endtask

    initial begin
        total      = 0;
        bad        = 0;
        reset      = 1'b1;
        Address    = A_LO;
        WriteData  = '0;
        MemWrite   = 1'b0;
        WriteMask  = 4'b0000;
        cons_ready = 1'b0;
        cyc();
        cyc();
        check("rst_rdata", ReadData, 32'h0);
        check("rst_valid", {31'b0, cons_valid}, 32'd0);
        check("rst_cdata", {24'b0, cons_data}, 32'd0);
        reset = 1'b0;

        // Timer starts at zero and counts every cycle.
        rd(A_LO, 32'd0, "time0");
        rd(A_LO, 32'd1, "time1");

        // Full and partial stores, exact one-cycle read latency.
        wr(32'h100, 32'hDEADBEEF, 4'b1111);
        rd(32'h100, 32'hDEADBEEF, "ram_full");
        wr(32'h100, 32'h0000AB00, 4'b0010);
        rd(32'h100, 32'hDEADABEF, "ram_mask0010");
        wr(32'h100, 32'h12340000, 4'b1100);
        rd(32'h100, 32'h1234ABEF, "ram_mask1100");

        // Read-during-write returns the old word.
        Address   = 32'h100;
        WriteData = 32'h00000055;
        WriteMask = 4'b0001;
        MemWrite  = 1'b1;
        exp_q.push_back(32'h1234ABEF);
        cyc();
        check("rdw_old", ReadData, exp_q.pop_front());
        MemWrite  = 1'b0;
        WriteMask = 4'b0000;
        rd(32'h100, 32'h1234AB55, "rdw_new");

        // Empty mask, out-of-range alias and last RAM word.
        wr(32'h100, 32'hFFFFFFFF, 4'b0000);
        rd(32'h100, 32'h1234AB55, "mask0");
        wr(32'h4100, 32'hBAD0BAD0, 4'b1111);
        rd(32'h100, 32'h1234AB55, "no_alias");
        rd(32'h4100, 32'h0, "beyond_ram");
        wr(32'h3FFC, 32'hA5A5A5A5, 4'b1111);
        rd(32'h3FFC, 32'hA5A5A5A5, "last_word");

        // IO reads
        rd(A_TX, 32'h0, "tx_read");
        rd(IO + 32'h10, 32'h0, "io_hole");
        rd(A_STAT, 32'h0000_0002, "stat_idle");

        // CONS_TX ignores lanes other than byte 0.
        wr(A_TX, 32'h00007700, 4'b0010);
        rd(A_STAT, 32'h0000_0002, "tx_lane1");

        // Overflow: 17 pushes into 16 entries.
        for (int i = 0; i < 17; i++) begin
            wr(A_TX, {24'hFFFFFF, 8'hA0 + 8'(i)}, 4'b0001);
            if (i < 16) byte_q.push_back(8'hA0 + 8'(i));
        end
        rd(A_STAT, 32'h0000_1005, "stat_ovf");
        drain("drain1");
        rd(A_STAT, 32'h0000_0006, "stat_sticky");
        wr(A_STAT, 32'h0, 4'b0001);
        rd(A_STAT, 32'h0000_0002, "stat_clr");

        // Push and pop together on a full FIFO: accepted, count unchanged.
        for (int i = 0; i < 16; i++) begin
            wr(A_TX, {24'h0, 8'hB0 + 8'(i)}, 4'b0001);
            byte_q.push_back(8'hB0 + 8'(i));
        end
        cons_ready = 1'b1;
        void'(byte_q.pop_front());
        byte_q.push_back(8'hC0);
        wr(A_TX, 32'h000000C0, 4'b0001);
        cons_ready = 1'b0;
        rd(A_STAT, 32'h0000_1001, "stat_full_pp");
        drain("drain2");

        // Timer shadow: HI returns the word captured with the LO read.
        force dut.timer_q = 64'h0000_0000_FFFF_FFFF;
        rd(A_LO, 32'hFFFF_FFFF, "lo_wrap");
        release dut.timer_q;
        rd(A_STAT, 32'h0000_0002, "gap0");
        rd(A_HI, 32'h0000_0000, "hi_shadow0");
        force dut.timer_q = 64'h0000_0007_FFFF_FFFF;
        rd(A_LO, 32'hFFFF_FFFF, "lo_wrap7");
        release dut.timer_q;
        rd(A_STAT, 32'h0000_0002, "gap7");
        rd(A_HI, 32'h0000_0007, "hi_shadow7");

        // Reset in the middle of a store.
        wr(32'h200, 32'hCAFEF00D, 4'b1111);
        wr(A_TX, 32'h00000042, 4'b0001);
        check("pre_rst_valid", {31'b0, cons_valid}, 32'd1);
        reset     = 1'b1;
        Address   = 32'h200;
        WriteData = 32'h11111111;
        WriteMask = 4'b1111;
        MemWrite  = 1'b1;
        cyc();
        reset     = 1'b0;
        MemWrite  = 1'b0;
        WriteMask = 4'b0000;
        check("mid_rst_rdata", ReadData, 32'h0);
        check("mid_rst_valid", {31'b0, cons_valid}, 32'd0);
        check("mid_rst_cdata", {24'b0, cons_data}, 32'd0);
        rd(32'h200, 32'hCAFEF00D, "store_suppressed");
        rd(32'h4000_0000, 32'h0, "unmapped");
        rd(A_STAT, 32'h0000_0002, "stat_after_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
